// File: rtl/data_mem.sv
// data_mem: data-memory responder for the memory-access stage.
//
// Takes a request on each rising clk edge where memCe=1. A legal write
// updates the selected byte lanes of one 32-bit word. A legal read returns
// the word one cycle later, lane-aligned, with unselected lanes forced to
// zero. Lane shifting and sign/zero extension are left to write-back.
// Illegal requests are dropped: no array write and no counter update.
// They set a sticky error flag that records the address of the first
// offending request. An illegal read still returns zero and pulses
// rdValid, so the pipeline never stalls.
//
// Ports:
//   clk      clock, all state on rising edge
//   rst      asynchronous active-low reset
//   memCe    request valid
//   memWr    write strobe
//   memRr    read strobe
//   memAddr  byte address; word = memAddr[ADDR_WIDTH+1:2], lane = memAddr[1:0]
//   wtData   lane-aligned store data
//   w_mask   write byte-lane enables
//   r_mask   read byte-lane enables
//   errClr   clears the sticky error record
//   rdData   lane-aligned load data, unselected lanes zero
//   rdValid  one-cycle pulse: rdData was updated by the previous-edge read
//   memErr   sticky illegal-request flag
//   errAddr  address of the first illegal request since the last clear
//   rdCount  accepted reads, wraps
//   wrCount  accepted writes, wraps
module data_mem #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic        memRr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  input  logic [3:0]  w_mask,
  input  logic [3:0]  r_mask,
  input  logic        errClr,
  output logic [31:0] rdData,
  output logic        rdValid,
  output logic        memErr,
  output logic [31:0] errAddr,
  output logic [15:0] rdCount,
  output logic [15:0] wrCount
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane_off;
  logic [3:0]            act_mask;
  logic                  mask_ok;
  logic                  range_ok;
  logic                  strobe_ok;
  logic                  illegal;
  logic                  wr_ok;
  logic                  rd_req;
  logic [31:0]           rd_word;
  logic [31:0]           rd_lanes;

  logic [31:0] rdData_q,  rdData_d;
  logic        rdValid_q, rdValid_d;
  logic        memErr_q,  memErr_d;
  logic [31:0] errAddr_q, errAddr_d;
  logic [15:0] rdCount_q, rdCount_d;
  logic [15:0] wrCount_q, wrCount_d;

  assign word_idx = memAddr[ADDR_WIDTH+1:2];
  assign lane_off = memAddr[1:0];
  assign act_mask = memWr ? w_mask : r_mask;

  // Legal shapes: full word at offset 0, halfword on a halfword
  // boundary, or a single byte whose lane matches the address offset.
  always_comb begin
    mask_ok = 1'b0;
    unique case (act_mask)
      4'b1111: mask_ok = (lane_off == 2'd0);
      4'b0011: mask_ok = (lane_off == 2'd0);
      4'b1100: mask_ok = (lane_off == 2'd2);
      4'b0001: mask_ok = (lane_off == 2'd0);
      4'b0010: mask_ok = (lane_off == 2'd1);
      4'b0100: mask_ok = (lane_off == 2'd2);
      4'b1000: mask_ok = (lane_off == 2'd3);
      default: mask_ok = 1'b0;
    endcase
  end

  // Any address bit above the word index puts the request out of range.
  assign range_ok  = ((memAddr >> (ADDR_WIDTH + 2)) == '0);
  assign strobe_ok = memWr ^ memRr;
  assign illegal   = memCe && !(strobe_ok && mask_ok && range_ok);
  assign wr_ok     = memCe && memWr && !illegal;
  assign rd_req    = memCe && memRr;

  // The array has no reset. rst is sampled here so that a write arriving
  // on an edge where reset is held is dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_mask[i]) begin
          mem[word_idx][8*i +: 8] <= wtData[8*i +: 8];
        end
      end
    end
  end

  assign rd_word = mem[word_idx];

  always_comb begin
    rd_lanes = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_mask[i]) begin
        rd_lanes[8*i +: 8] = rd_word[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdData_d  = rdData_q;
    rdValid_d = 1'b0;
    memErr_d  = memErr_q;
    errAddr_d = errAddr_q;
    rdCount_d = rdCount_q;
    wrCount_d = wrCount_q;

    // Any read strobe produces a response; an illegal one returns zero.
    if (rd_req) begin
      rdValid_d = 1'b1;
      rdData_d  = illegal ? '0 : rd_lanes;
    end

    if (rd_req && !illegal) begin
      rdCount_d = rdCount_q + 16'd1;
    end
    if (wr_ok) begin
      wrCount_d = wrCount_q + 16'd1;
    end

    // A clear on the same edge as an illegal request loses to the request:
    // the old record is discarded and this address becomes the first error.
    if (illegal) begin
      memErr_d = 1'b1;
      if (!memErr_q || errClr) begin
        errAddr_d = memAddr;
      end
    end else if (errClr) begin
      memErr_d  = 1'b0;
      errAddr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
      memErr_q  <= 1'b0;
      errAddr_q <= '0;
      rdCount_q <= '0;
      wrCount_q <= '0;
    end else begin
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
      memErr_q  <= memErr_d;
      errAddr_q <= errAddr_d;
      rdCount_q <= rdCount_d;
      wrCount_q <= wrCount_d;
    end
  end

  assign rdData  = rdData_q;
  assign rdValid = rdValid_q;
  assign memErr  = memErr_q;
  assign errAddr = errAddr_q;
  assign rdCount = rdCount_q;
  assign wrCount = wrCount_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem.
// The driver applies one request per cycle on the falling edge. A
// reference model computes the response from the access rules, and the
// expected post-edge status and read data go into queues. A monitor
// samples just after each rising edge and compares the outputs with the
// queue entries.
module tb_data_mem;

  localparam int unsigned AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        memCe, memWr, memRr, errClr;
  logic [31:0] memAddr, wtData;
  logic [3:0]  w_mask, r_mask;
  logic [31:0] rdData;
  logic        rdValid, memErr;
  logic [31:0] errAddr;
  logic [15:0] rdCount, wrCount;

  data_mem #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .memCe(memCe), .memWr(memWr), .memRr(memRr),
    .memAddr(memAddr), .wtData(wtData), .w_mask(w_mask), .r_mask(r_mask),
    .errClr(errClr), .rdData(rdData), .rdValid(rdValid), .memErr(memErr),
    .errAddr(errAddr), .rdCount(rdCount), .wrCount(wrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic [31:0] ea;
    logic [15:0] rc;
    logic [15:0] wc;
  } status_t;

  status_t     stq[$];
  logic [31:0] rq[$];

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          mon_en = 1'b0;

  // Reference model state.
  logic [31:0] m_mem [0:(1<<AW)-1];
  logic [31:0] m_rd;
  logic        m_err;
  logic [31:0] m_ea;
  logic [15:0] m_rc, m_wc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal access shapes, stated as the list of allowed (mask, offset) pairs.
  function automatic bit legal_shape(input logic [3:0] m, input logic [1:0] off);
    logic [3:0] ok_m [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [1:0] ok_o [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int k = 0; k < 7; k++)
      if (m == ok_m[k] && off == ok_o[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  task automatic model_step(input logic ce, input logic wr, input logic rd,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] wm, input logic [3:0] rm,
                            input logic clr);
    status_t s;
    bit      bad;
    int      w;
    logic [3:0] am;
    am  = wr ? wm : rm;
    bad = ce && ((wr == rd) || !legal_shape(am, a[1:0]) || (a >= (32'd4 << AW)));
    w   = int'(a[AW+1:2]);
    s.rv = 1'b0;
    if (ce && rd) begin
      s.rv = 1'b1;
      m_rd = bad ? 32'h0 : lanes(m_mem[w], rm);
      rq.push_back(m_rd);
      if (!bad) m_rc = m_rc + 16'd1;
    end
    if (ce && wr && !bad) begin
      m_mem[w] = lanes(wd, wm) | (m_mem[w] & ~lanes(32'hFFFF_FFFF, wm));
      m_wc = m_wc + 16'd1;
    end
    if (bad) begin
      if (!m_err || clr) m_ea = a;
      m_err = 1'b1;
    end else if (clr) begin
      m_err = 1'b0;
      m_ea  = 32'h0;
    end
    s.rd = m_rd; s.err = m_err; s.ea = m_ea; s.rc = m_rc; s.wc = m_wc;
    stq.push_back(s);
  endtask

  task automatic cyc(input logic ce, input logic wr, input logic rd,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] wm, input logic [3:0] rm,
                     input logic clr);
    @(negedge clk);
    memCe = ce; memWr = wr; memRr = rd; memAddr = a; wtData = wd;
    w_mask = wm; r_mask = rm; errClr = clr;
    model_step(ce, wr, rd, a, wd, wm, rm, clr);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic model_reset();
    m_rd = 32'h0; m_err = 1'b0; m_ea = 32'h0; m_rc = 16'h0; m_wc = 16'h0;
  endtask

  // Monitor: one status entry per cycle; read data popped on rdValid.
  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      if (stq.size() != 0) begin
        status_t s;
        s = stq.pop_front();
        chk("rdValid", {31'h0, rdValid}, {31'h0, s.rv});
        chk("rdData_hold", rdData, s.rd);
        chk("memErr", {31'h0, memErr}, {31'h0, s.err});
        chk("errAddr", errAddr, s.ea);
        chk("rdCount", {16'h0, rdCount}, {16'h0, s.rc});
        chk("wrCount", {16'h0, wrCount}, {16'h0, s.wc});
        if (rdValid === 1'b1) begin
          if (rq.size() == 0) begin
            chk("rd_spurious", 32'h1, 32'h0);
          end else begin
            chk("rd_scoreboard", rdData, rq.pop_front());
          end
        end
      end
    end
  end

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0]  pm [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [1:0]  po [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] a, old5;
    logic [3:0]  mk;
    logic        ce, wr, rd;
    int unsigned op, k;

    rst = 1'b0; memCe = 0; memWr = 0; memRr = 0; memAddr = 0; wtData = 0;
    w_mask = 0; r_mask = 0; errClr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rdData", rdData, 32'h0);
    chk("reset_rdValid", {31'h0, rdValid}, 32'h0);
    chk("reset_memErr", {31'h0, memErr}, 32'h0);
    chk("reset_errAddr", errAddr, 32'h0);
    chk("reset_rdCount", {16'h0, rdCount}, 32'h0);
    chk("reset_wrCount", {16'h0, wrCount}, 32'h0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Directed cases.
    cyc(1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 4'h0, 0);
    cyc(1, 0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 0);
    cyc(1, 1, 0, 32'h11, 32'h0000AA00, 4'h2, 4'h0, 0);
    cyc(1, 0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 0);
    cyc(1, 0, 1, 32'h12, 32'h0, 4'h0, 4'hC, 0);
    cyc(1, 1, 0, 32'h12, 32'h12345678, 4'h3, 4'h0, 0);
    cyc(1, 1, 0, 32'h21, 32'h0, 4'h3, 4'h0, 0);
    cyc(1, 0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 0);
    cyc(0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 1);
    cyc(1, 0, 1, 32'h0000_1000, 32'h0, 4'h0, 4'hF, 0);
    cyc(1, 1, 1, 32'h0, 32'h55555555, 4'hF, 4'hF, 0);
    cyc(1, 1, 0, 32'h0, 32'h0, 4'h0, 4'h0, 1);
    cyc(1, 0, 1, 32'h8, 32'h0, 4'h0, 4'h1, 1);

    // Initialise words 0..15, then back-to-back reads.
    for (int i = 0; i < 16; i++)
      cyc(1, 1, 0, 32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF, 4'h0, 0);
    cyc(1, 0, 1, 32'h0, 32'h0, 4'h0, 4'hF, 0);
    cyc(1, 0, 1, 32'h4, 32'h0, 4'h0, 4'hF, 0);
    cyc(1, 0, 1, 32'h8, 32'h0, 4'h0, 4'hF, 0);
    idle();
    idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      a  = 32'($urandom_range(0, 15)) << 2;
      mk = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) begin
        k  = $urandom_range(0, 6);
        mk = pm[k];
        a[1:0] = po[k];
      end else begin
        a[1:0] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      op = $urandom_range(0, 9);
      wr = (op < 4) || (op == 8);
      rd = (op >= 4 && op < 9);
      ce = ($urandom_range(0, 7) != 0);
      cyc(ce, wr, rd, a, $urandom, mk, mk, ($urandom_range(0, 15) == 0));
    end
    idle();

    // Asynchronous reset with a write held on the same edge.
    drain();
    mon_en = 1'b0;
    stq.delete();
    rq.delete();
    old5 = m_mem[5];
    @(negedge clk);
    memCe = 1; memWr = 1; memRr = 0; memAddr = 32'h14; wtData = ~old5;
    w_mask = 4'hF; r_mask = 4'h0; errClr = 0;
    #2 rst = 1'b0;
    #1;
    chk("async_rdData", rdData, 32'h0);
    chk("async_rdValid", {31'h0, rdValid}, 32'h0);
    chk("async_memErr", {31'h0, memErr}, 32'h0);
    chk("async_errAddr", errAddr, 32'h0);
    chk("async_rdCount", {16'h0, rdCount}, 32'h0);
    chk("async_wrCount", {16'h0, wrCount}, 32'h0);
    @(negedge clk);
    memCe = 0; memWr = 0;
    rst = 1'b1;
    model_reset();
    mon_en = 1'b1;
    cyc(1, 0, 1, 32'h14, 32'h0, 4'h0, 4'hF, 0);
    idle();

    // Write counter wrap.
    for (int i = 0; i < 65536; i++)
      cyc(1, 1, 0, 32'($urandom_range(0, 15)) << 2, $urandom, 4'hF, 4'h0, 0);
    cyc(1, 0, 1, 32'h0, 32'h0, 4'h0, 4'hF, 0);
    idle();
    drain();
    chk("wrap_wrCount", {16'h0, wrCount}, 32'h0);
    chk("rd_queue_empty", rq.size(), 32'h0);
    chk("st_queue_empty", stq.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/data_mem.md
# data_mem

Data-memory responder for the pipeline's memory-access stage: accepts the stage's request bundle (chip enable, read/write strobes, byte-lane masks, address, store data) and returns lane-aligned load data one cycle later. Byte-granular writes, registered reads, alignment and range checking with a sticky error record, and wrapping access counters for debug. It sits between the memory-access stage and write-back; sign/zero extension and lane shifting of load data are done downstream in write-back.

## Interface
- ADDR_WIDTH, 10, word-address width; capacity 2^ADDR_WIDTH 32-bit words
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- memCe  in  1  request valid
- memWr  in  1  write strobe
- memRr  in  1  read strobe
- memAddr  in  32  byte address
- wtData  in  32  store data, already lane-aligned (byte i on bits 8i+7:8i)
- w_mask  in  4  write byte-lane enables
- r_mask  in  4  read byte-lane enables
- errClr  in  1  clears sticky error record
- rdData  out  32  load data, lane-aligned, unselected lanes zero
- rdValid  out  1  one-cycle pulse: rdData updated by previous-edge read
- memErr  out  1  sticky: an illegal request was received
- errAddr  out  32  memAddr of the first illegal request since last clear
- rdCount  out  16  accepted reads, wraps
- wrCount  out  16  accepted writes, wraps

## Operation
- Request sampled on rising edge when memCe=1; memCe=0 means no action regardless of other inputs.
- Word index = memAddr[ADDR_WIDTH+1:2]; lane offset = memAddr[1:0].
- Active mask = w_mask for writes, r_mask for reads. Legal: 4'b1111 with offset 0; 4'b0011 with offset 0; 4'b1100 with offset 2; one-hot mask with bit index == offset.
- Illegal request (any of): memWr and memRr both 1; neither strobe 1; active mask not legal; memAddr[31:ADDR_WIDTH+2] != 0.
- Legal write: each lane i with w_mask[i]=1 gets wtData[8i+7:8i]; other lanes unchanged; wrCount += 1.
- Legal read: rdData lane i = mem[word] lane i if r_mask[i] else 8'h00; rdValid=1 next cycle; rdCount += 1.
- Illegal request: no array write, counters unchanged; an illegal read still loads rdData=0 and pulses rdValid so the pipeline never stalls; memErr set; errAddr captured only if memErr was 0 (first-error record).
- errClr=1: memErr and errAddr cleared at the edge; an illegal request at the same edge wins (memErr=1, errAddr = that address).
- Counters wrap 16'hFFFF -> 16'h0000.
- Memory array not reset; contents undefined until written.

## Timing
- Reset (rst=0, asynchronous): rdData=0, rdValid=0, memErr=0, errAddr=0, rdCount=0, wrCount=0. A request at an edge while rst=0 is dropped; the first request honoured is at the first edge with rst=1.
- Write latency: array updated at the sampling edge; a read of the same word sampled on the next edge returns the new data.
- Read latency: 1 cycle. rdData changes only at an edge with memCe=1 and memRr=1 (legal or illegal); otherwise it holds its last value.
- rdValid high exactly one cycle per read; back-to-back reads keep rdValid high continuously with new data each cycle.
- No backpressure: one request per cycle accepted unconditionally.

## Test plan
- Reset then write 32'hDEADBEEF, w_mask=1111, addr 0x10; read addr 0x10, r_mask=1111 -> next cycle rdData=32'hDEADBEEF, rdValid=1, wrCount=1, rdCount=1.
- Byte write 32'h0000AA00, w_mask=0010, addr 0x11, onto 32'hDEADBEEF; read full word -> 32'hDEADAAEF; read r_mask=1100 at addr 0x12 -> 32'hDEAD0000.
- Misaligned halfword: w_mask=0011 at addr 0x12 -> word unchanged, memErr=1, errAddr=0x12, wrCount unchanged; second illegal at 0x21 -> errAddr stays 0x12; errClr -> memErr=0, errAddr=0.
- Out of range (ADDR_WIDTH=10): read addr 0x0000_1000 -> rdData=0, rdValid=1, memErr=1, rdCount unchanged; memWr=memRr=1 at addr 0 -> memErr=1, no write.
- Back-to-back reads of addrs 0x0,0x4,0x8 after distinct writes -> rdValid high three consecutive cycles, data in order; memCe=0 next -> rdValid=0, rdData holds.
- Drive rst low mid-stream with a write pending on the same edge -> outputs zero immediately, write not performed; 65536 legal writes -> wrCount wraps to 0.
